// File: rtl/switch_level_inv_tester.sv
// switch_level_inv_tester
// Drives a single-input inverter cell from a deterministic pattern stream,
// waits a programmable settle time, samples the cell output and checks
// that y is the complement of a. Pass/fail statistics accumulate per run.
module switch_level_inv_tester #(
  parameter int          N_VEC      = 16,
  parameter int          SETTLE_CYC = 2,
  parameter int          CNT_W      = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  // Settle counter only needs to hold SETTLE_CYC-1.
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               dut_a_q, dut_a_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   ffi_q, ffi_d;
  logic               lfsr_fb;
  logic               mismatch;

  // Fibonacci feedback for taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic lfsr_feedback(input logic [7:0] l);
    return l[7] ^ l[5] ^ l[4] ^ l[3];
  endfunction

  // Next-state and datapath decode; every register holds unless a state updates it.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    set_d    = set_q;
    dut_a_d  = dut_a_q;
    pass_d   = pass_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    lfsr_fb  = lfsr_feedback(lfsr_q);
    // Case inequality so an X or Z on the cell output is a failure.
    mismatch = (dut_y !== ~dut_a_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          vec_d   = {CNT_W{1'b0}};
          err_d   = {CNT_W{1'b0}};
          ffi_d   = {CNT_W{1'b1}};
          lfsr_d  = LFSR_SEED;
          pass_d  = 1'b0;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (mode_q) begin
          dut_a_d = lfsr_q[0];
        end else begin
          dut_a_d = vec_q[0];
        end
        set_d   = SET_W'(SETTLE_CYC - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_q == {SET_W{1'b0}}) begin
          state_d = ST_SAMPLE;
        end else begin
          set_d   = set_q - SET_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != {CNT_W{1'b1}}) begin
            err_d = err_q + CNT_W'(1);
          end else begin
            err_d = err_q;
          end
          if (ffi_q == {CNT_W{1'b1}}) begin
            ffi_d = vec_q;
          end else begin
            ffi_d = ffi_q;
          end
        end else begin
          err_d = err_q;
        end
        vec_d  = vec_q + CNT_W'(1);
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (vec_d == CNT_W'(N_VEC)) begin
          // Verdict is registered on entry so it is visible with done.
          pass_d  = (err_d == {CNT_W{1'b0}});
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      set_q   <= {SET_W{1'b0}};
      dut_a_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= {CNT_W{1'b0}};
      err_q   <= {CNT_W{1'b0}};
      ffi_q   <= {CNT_W{1'b1}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      set_q   <= set_d;
      dut_a_q <= dut_a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
    end
  end

  assign dut_a          = dut_a_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_switch_level_inv_tester.sv
// Bench for switch_level_inv_tester: emulates several inverter cells
// (ideal, stuck-at, buffer, floating) and checks every run against a
// reference computed directly from the pattern and check rules.
module tb_switch_level_inv_tester;
  localparam int N   = 16;
  localparam int S   = 2;
  localparam int P   = 2 + S;
  localparam int LAT = 1 + N * P;

  logic       clk = 1'b0;
  logic       rst, start, mode, dut_a, dut_y;
  logic       busy, done, pass;
  logic [7:0] vec_count, err_count, first_fail_idx;
  logic       y_ideal_q;
  logic       zv = 1'bz;
  int         model = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  switch_level_inv_tester #(.N_VEC(N), .SETTLE_CYC(S), .CNT_W(8), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dut_a(dut_a), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  // Ideal inverter with one cycle of delay.
  always @(posedge clk) y_ideal_q <= ~dut_a;

  // Select the emulated cell.
  always @* begin
    case (model)
      0:       dut_y = y_ideal_q;
      1:       dut_y = 1'b0;
      2:       dut_y = 1'b1;
      3:       dut_y = dut_a;
      default: dut_y = zv;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stimulus: alternating bits, or bit 0 of an LFSR walked arithmetically.
  function automatic logic [31:0] pattern(input bit m);
    int l = 'hA5;
    int fb;
    logic [31:0] p = 32'd0;
    for (int i = 0; i < N; i++) begin
      p[i] = m ? l[0] : (i % 2 == 1);
      fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
      l  = ((l << 1) & 255) | fb;
    end
    return p;
  endfunction

  // Does the emulated cell disagree with y == ~a for stimulus bit a?
  function automatic bit cell_fails(input int mdl, input logic a);
    case (mdl)
      0: return 1'b0;
      1: return (a == 1'b0);
      2: return (a == 1'b1);
      3: return 1'b1;
      default: return $isunknown(zv) ? 1'b1 : (zv == a);
    endcase
  endfunction

  task automatic do_run(input int mdl, input bit md, input int gap, input int extra_t);
    logic [31:0] p, seq;
    int exp_err, exp_ffi, t, done_t;
    logic b_at_done, p_at_done;
    logic [7:0] v_at_done, e_at_done, f_at_done;
    p = pattern(md);
    exp_err = 0;
    exp_ffi = 'hFF;
    for (int i = 0; i < N; i++) begin
      if (cell_fails(mdl, p[i])) begin
        if (exp_ffi == 'hFF) exp_ffi = i;
        exp_err++;
      end
    end
    model = mdl;
    repeat (gap) @(negedge clk);
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom);
    seq = 32'd0; done_t = -1;
    b_at_done = 1'b0; p_at_done = 1'b0;
    v_at_done = 8'd0; e_at_done = 8'd0; f_at_done = 8'd0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (t = 1; t <= LAT; t++) begin
      start = (t == extra_t);
      if (t % P == 2 && (t - 2) / P < N) seq[(t - 2) / P] = dut_a;
      if (done && done_t < 0) begin
        done_t = t; b_at_done = busy; p_at_done = pass;
        v_at_done = vec_count; e_at_done = err_count; f_at_done = first_fail_idx;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_cycle", done_t, LAT);
    check("busy_at_done", {31'd0, b_at_done}, 32'd1);
    check("pass", {31'd0, p_at_done}, (exp_err == 0) ? 32'd1 : 32'd0);
    check("vec_count", {24'd0, v_at_done}, N);
    check("err_count", {24'd0, e_at_done}, exp_err);
    check("first_fail_idx", {24'd0, f_at_done}, exp_ffi);
    check("dut_a_seq", seq, p);
    check("done_after", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_dut_a", {31'd0, dut_a}, 32'd0);
    check("rst_vec", {24'd0, vec_count}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    check("rst_ffi", {24'd0, first_fail_idx}, 32'hFF);

    // Directed cells and modes.
    do_run(0, 1'b0, 4, -1);
    do_run(1, 1'b0, 2, -1);
    do_run(2, 1'b0, 2, -1);
    do_run(3, 1'b0, 2, -1);
    do_run(0, 1'b1, 2, -1);
    do_run(4, 1'b0, 2, -1);
    // A start pulse mid-run must be ignored.
    do_run(0, 1'b0, 2, 20);

    // Reset mid-run aborts without a done pulse.
    model = 1;
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_vec", {24'd0, vec_count}, 32'd0);
    check("abort_err", {24'd0, err_count}, 32'd0);
    check("abort_ffi", {24'd0, first_fail_idx}, 32'hFF);
    check("abort_dut_a", {31'd0, dut_a}, 32'd0);
    dones = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("abort_no_done", dones, 0);

    // A fresh run after the abort, then randomized runs.
    do_run(0, 1'b0, 1, -1);
    for (int r = 0; r < 10; r++) begin
      do_run(int'($urandom_range(4, 0)), 1'($urandom), int'($urandom_range(5, 1)),
             ($urandom_range(1, 0) == 1) ? int'($urandom_range(60, 2)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_level_inv_tester.md
Name: switch_level_inv_tester

Overview:
- Self-checking driver/monitor for the switch-level CMOS inverter cells in this collection.
- Drives the cell's input `a` from a deterministic vector stream and waits a programmable settle time.
- Samples the cell's output `y` and checks y == ~a, accumulating pass/fail statistics.
- Sits at the opposite end of the inverter's a→y interface and wraps any single-input/single-output inverter cell in simulation.

Parameters:
- N_VEC, 16: number of vectors per run (1..2^CNT_W-1).
- SETTLE_CYC, 2: clock cycles `dut_a` is held before `y` is sampled (>=1).
- CNT_W, 8: width of the vector counter, error counter and index registers.
- LFSR_SEED, 8'hA5: seed for pattern mode 1; must be nonzero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- mode  input  1  pattern select, sampled with start: 0 = alternating 0,1,0,1…; 1 = LFSR bit 0.
- dut_a  output  1  stimulus to the inverter input.
- dut_y  input  1  inverter output under test.
- busy  output  1  high from the cycle after an accepted start through the cycle done is high.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  valid when done=1 and held until the next accepted start; 1 iff err_count==0.
- vec_count  output  CNT_W  vectors checked so far in the current run.
- err_count  output  CNT_W  mismatches so far; saturates at all-ones.
- first_fail_idx  output  CNT_W  index of the first failing vector; all-ones if none.

Behaviour:
- Reset values: all outputs 0, except first_fail_idx = all-ones; FSM = IDLE; LFSR = LFSR_SEED.
- rst mid-run aborts immediately to the reset state. No done pulse is produced.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches mode, clears vec_count and err_count, sets first_fail_idx = all-ones, reloads the LFSR with LFSR_SEED, then goes to DRIVE.
  - Results from the previous run stay visible until start is accepted.
- DRIVE (1 cycle):
  - dut_a <= pattern bit for index vec_count.
  - Mode 0: bit = vec_count[0]. Mode 1: bit = lfsr[0].
  - Loads the settle counter with SETTLE_CYC-1, then goes to SETTLE.
- SETTLE: counter decrements each cycle; at 0, go to SAMPLE. This gives exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - Mismatch when dut_y !== ~dut_a (case inequality, so X or Z on dut_y counts as a failure).
  - On mismatch: err_count increments (saturating). If first_fail_idx is all-ones, it captures vec_count.
  - vec_count increments.
  - LFSR advances: Fibonacci, taps 8,6,5,4, shifting left with feedback into bit 0.
  - If the incremented vec_count == N_VEC, go to DONE; otherwise go to DRIVE.
- DONE (1 cycle): done=1, busy=1, pass = (err_count==0). Next state is IDLE, where busy=0.
- dut_a holds its last value between runs.
- start while busy is ignored and is not queued.
- start coincident with rst: rst wins.
- Latency: an accepted start at edge k gives done=1 in cycle k+1+N_VEC*(2+SETTLE_CYC).
  - With defaults, that is k+65.

Test Plan:
- Ideal inverter (y = ~a, 1-cycle delay model), defaults, mode 0, start at cycle 10 -> done at cycle 75; pass=1, vec_count=16, err_count=0, first_fail_idx=8'hFF; dut_a toggles 0,1,0,1…
- DUT stuck-at-0, mode 0 -> done; pass=0, err_count=8, first_fail_idx=0.
- DUT stuck-at-1 -> err_count=8, first_fail_idx=1.
- Buffer DUT (y=a) -> err_count=16, first_fail_idx=0.
- Mode 1 with an ideal inverter -> pass=1; dut_a sequence matches a reference model of the LFSR seeded with 8'hA5.
- dut_y = 1'bz -> err_count=16.
- start pulsed again at cycle 30 of a run -> ignored; done is still at cycle 75.
- rst asserted at cycle 40 -> next cycle busy=0, counts=0, first_fail_idx=8'hFF, dut_a=0; no done pulse.
- A new start then completes a full run normally.
